fma_operand_memory: RTL
=======================

Name: fma_operand_memory

Overview:
- Parametrised successor to the single-configuration operand memory that feeds the FMA array.
- Holds an on-chip line store, one line = FMA_COUNT x (a,b,c) words, plus a staging line and an address register.
- Executes a 32-bit memory instruction stream: immediate/ramp loads into staging, commit, read-to-FMA, and write-back from the FMA write buffer.
- Adds over the prior generation: generic FMA_COUNT and DEPTH, configurable read latency, ramp load into any of a/b/c, address increment with wrap, a write-back wait state with instruction back-pressure, and a sticky error flag.

Parameters:
- FMA_COUNT, 2, number of FMAs served per line
- WORD_WIDTH, 16, bits per word
- LINE_WIDTH, FMA_COUNT*3*WORD_WIDTH, line width (derived; do not override)
- DEPTH, 375, number of lines
- ADDR_LENGTH, $clog2(DEPTH), address register width
- READ_LATENCY, 2, store read pipeline stages (>=1)
- INSTRUCTION_WIDTH, 32, instruction width

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous, active-low reset
- controller_reg_a/b/c  input  WORD_WIDTH each  controller register values
- write_buffer_read_in  input  LINE_WIDTH  line from FMA write buffer
- write_buffer_valid_in  input  1  write_buffer_read_in valid
- instr_in  input  INSTRUCTION_WIDTH  instruction
- instr_valid_in  input  1  instruction valid
- instr_ready_out  output  1  instruction accepted when valid&&ready
- abc_out  output  LINE_WIDTH  operand line to FMAs
- abc_valid_out  output  1  one-cycle pulse, abc_out valid
- use_new_c_out  output  1  aligned with abc_valid_out
- fma_output_can_be_valid_out  output  1  aligned with abc_valid_out
- busy_out  output  1  high in WAIT_WB or while reads are in flight
- error_out  output  1  sticky error flag

Behaviour:
- Instruction fields: op=[31:28], idx=[27:24], imm=[23:8], unused [7:0].
- Word k of a line occupies bits [(k+1)*W-1 : k*W]. FMA i uses a=3i, b=3i+1, c=3i+2.
- Reset (rst_in low, asynchronous):
  - All outputs 0; instr_ready_out goes 1 on the first clock after release.
  - Staging line, addr_reg and in-flight reads cleared; FSM to IDLE.
  - Store contents undefined.
  - Reset mid-read or mid-WAIT_WB aborts the operation with no pulse and no write.
- 0000 NOP: no effect.
- 0001 SET_ADDR: addr_reg <= imm. If imm >= DEPTH: set error_out, addr_reg unchanged.
- 0011 ADDR_INC: addr_reg <= (addr_reg + imm) mod DEPTH. Wrap is not an error.
- 0111 LOAD_IMM: staging word idx <= imm. If idx >= 3*FMA_COUNT: set error_out, no write.
- 1101 LOAD_RAMP: field sel=idx[1:0] (0=a, 1=b, 2=c), source reg=idx[3:2] (0=a, 1=b, 2=c), diff=imm.
  - For every FMA i, staging word 3i+sel <= reg + i*diff, truncated to WORD_WIDTH.
  - Other words unchanged.
  - sel==3 or src==3: set error_out, no write.
- 1110 COMMIT: store[addr_reg] <= staging on the acceptance edge. Staging is retained.
- 1100 READ: captures store[addr_reg].
  - abc_out plus a one-cycle abc_valid_out exactly READ_LATENCY+1 cycles after the acceptance edge.
  - use_new_c_out <= imm[15] and fma_output_can_be_valid_out <= imm[14], both pulsed with abc_valid_out.
  - Back-to-back READs are accepted every cycle, fully pipelined.
  - abc_out holds its last value when not valid.
- 1010 WRITEBACK: IDLE -> WAIT_WB, instr_ready_out low.
  - On the first cycle with write_buffer_valid_in: store[addr_reg] <= write_buffer_read_in, return to IDLE.
  - instr_ready_out rises the following cycle.
  - A write_buffer_valid_in seen outside WAIT_WB is ignored.
- Ordering: a write accepted at cycle t is visible to a READ accepted at t+1 or later. The store must be read-after-write correct; bypass if the inferred RAM is not.
- Undefined opcodes: set error_out and behave as NOP.
- error_out clears only on reset.
- instr_ready_out is low only in WAIT_WB. Instructions with instr_valid_in low are ignored.

Test Plan:
- Reset, then SET_ADDR 8; LOAD_RAMP src=a, sel=a, diff=1 with reg_a=1; COMMIT; READ -> after 3 cycles abc_out words [1,0,0,2,0,0], abc_valid_out high for exactly 1 cycle.
- LOAD_IMM idx 0..5 with values 0x11..0x16; COMMIT at addr 3; READ addr 3 -> line 0x0016_0015_0014_0013_0012_0011.
- SET_ADDR 374; ADDR_INC 2 -> addr_reg = 1, error_out stays 0. SET_ADDR 400 -> error_out = 1, addr_reg = 1.
- WRITEBACK at addr 5 with write_buffer_valid_in held low 4 cycles -> instr_ready_out low throughout. Assert valid with 0xAA00_A000_A000_A000_A000_A000 -> ready returns; READ 5 returns that line.
- COMMIT addr 2 followed immediately by READ addr 2 -> new data returned. Four back-to-back READs -> four consecutive abc_valid_out pulses.
- Drop rst_in low during WAIT_WB and mid-READ -> all outputs 0 immediately, no stray abc_valid_out after release.

Source files
------------

// File: rtl/fma_operand_memory.sv
// Operand line store feeding the FMA array.
// Staging line, address register, pipelined reads, write-back wait state.
module fma_operand_memory #(
   parameter int FMA_COUNT         = 2,
   parameter int WORD_WIDTH        = 16,
   parameter int LINE_WIDTH        = FMA_COUNT*3*WORD_WIDTH,
   parameter int DEPTH             = 375,
   parameter int ADDR_LENGTH       = $clog2(DEPTH),
   parameter int READ_LATENCY      = 2,
   parameter int INSTRUCTION_WIDTH = 32
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [WORD_WIDTH-1:0]        controller_reg_a,
   input  logic [WORD_WIDTH-1:0]        controller_reg_b,
   input  logic [WORD_WIDTH-1:0]        controller_reg_c,
   input  logic [LINE_WIDTH-1:0]        write_buffer_read_in,
   input  logic                         write_buffer_valid_in,
   input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
   input  logic                         instr_valid_in,
   output logic                         instr_ready_out,
   output logic [LINE_WIDTH-1:0]        abc_out,
   output logic                         abc_valid_out,
   output logic                         use_new_c_out,
   output logic                         fma_output_can_be_valid_out,
   output logic                         busy_out,
   output logic                         error_out
);

   localparam int NWORDS = 3*FMA_COUNT;
   localparam int WIDX   = $clog2(NWORDS);
   localparam int RL     = READ_LATENCY;

   localparam logic [3:0] OP_NOP    = 4'b0000;
   localparam logic [3:0] OP_SET    = 4'b0001;
   localparam logic [3:0] OP_INC    = 4'b0011;
   localparam logic [3:0] OP_IMM    = 4'b0111;
   localparam logic [3:0] OP_RAMP   = 4'b1101;
   localparam logic [3:0] OP_COMMIT = 4'b1110;
   localparam logic [3:0] OP_READ   = 4'b1100;
   localparam logic [3:0] OP_WB     = 4'b1010;

   typedef enum logic [0:0] {
      S_IDLE,
      S_WAIT_WB
   } state_t;

   typedef logic [NWORDS-1:0][WORD_WIDTH-1:0] line_t;

   state_t                  state_q, state_d;
   logic                    ready_q;
   logic [ADDR_LENGTH-1:0]  addr_q, addr_d;
   line_t                   stage_q, stage_d;
   logic                    err_q, err_d;

   logic [LINE_WIDTH-1:0]   mem_q [DEPTH];
   logic [LINE_WIDTH-1:0]   rd_q;
   logic [LINE_WIDTH-1:0]   pipe_q [1:RL];
   logic [RL:0]             vld_q;
   logic [RL:0]             ucn_q;
   logic [RL:0]             fov_q;

   logic [LINE_WIDTH-1:0]   abc_q;
   logic                    abc_vld_q;
   logic                    ucn_out_q;
   logic                    fov_out_q;

   logic                    accept;
   logic [3:0]              op;
   logic [3:0]              idx;
   logic [15:0]             imm;
   logic [1:0]              sel;
   logic [1:0]              srcsel;
   logic                    mem_we;
   logic [LINE_WIDTH-1:0]   mem_wdata;
   logic                    rd_en;
   logic [WORD_WIDTH-1:0]   src_val;
   logic [WORD_WIDTH-1:0]   diff_w;
   logic [31:0]             sum32;
   logic                    unused_bits;

   assign op          = instr_in[31:28];
   assign idx         = instr_in[27:24];
   assign imm         = instr_in[23:8];
   assign sel         = idx[1:0];
   assign srcsel      = idx[3:2];
   assign unused_bits = ^instr_in[7:0];
   assign accept      = instr_valid_in & ready_q;
   assign diff_w      = WORD_WIDTH'(imm);

   // Decode the accepted instruction and drive the write-back wait state.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      stage_d   = stage_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      mem_wdata = stage_q;
      rd_en     = 1'b0;
      sum32     = 32'(addr_q) + 32'(imm);
      case (srcsel)
         2'd0:    src_val = controller_reg_a;
         2'd1:    src_val = controller_reg_b;
         default: src_val = controller_reg_c;
      endcase
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               unique case (op)
                  OP_NOP: begin
                  end
                  OP_SET: begin
                     if (32'(imm) >= DEPTH) err_d = 1'b1;
                     else addr_d = ADDR_LENGTH'(imm);
                  end
                  OP_INC: begin
                     addr_d = ADDR_LENGTH'(sum32 % 32'(DEPTH));
                  end
                  OP_IMM: begin
                     if (32'(idx) >= NWORDS) err_d = 1'b1;
                     else stage_d[WIDX'(idx)] = WORD_WIDTH'(imm);
                  end
                  OP_RAMP: begin
                     if (sel == 2'd3 || srcsel == 2'd3) begin
                        err_d = 1'b1;
                     end else begin
                        for (int i = 0; i < FMA_COUNT; i++) begin
                           stage_d[WIDX'(3*i) + WIDX'(sel)] =
                              src_val + WORD_WIDTH'(i) * diff_w;
                        end
                     end
                  end
                  OP_COMMIT: begin
                     mem_we = 1'b1;
                  end
                  OP_READ: begin
                     rd_en = 1'b1;
                  end
                  OP_WB: begin
                     state_d = S_WAIT_WB;
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
            end
         end
         S_WAIT_WB: begin
            if (write_buffer_valid_in) begin
               mem_we    = 1'b1;
               mem_wdata = write_buffer_read_in;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state: FSM, ready, address, staging line, sticky error.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         addr_q  <= '0;
         stage_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == S_IDLE);
         addr_q  <= addr_d;
         stage_q <= stage_d;
         err_q   <= err_d;
      end
   end

   // Line store; write and read never share an edge, so reads see prior writes.
   always_ff @(posedge clk_in) begin
      if (mem_we) mem_q[addr_q] <= mem_wdata;
      if (rd_en) rd_q <= mem_q[addr_q];
   end

   // Read pipeline: flags and data advance one stage per cycle.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         vld_q <= '0;
         ucn_q <= '0;
         fov_q <= '0;
         for (int k = 1; k <= RL; k++) pipe_q[k] <= '0;
      end else begin
         vld_q <= {vld_q[RL-1:0], rd_en};
         ucn_q <= {ucn_q[RL-1:0], imm[15]};
         fov_q <= {fov_q[RL-1:0], imm[14]};
         pipe_q[1] <= rd_q;
         for (int k = 2; k <= RL; k++) pipe_q[k] <= pipe_q[k-1];
      end
   end

   // Output register: pulse flags, hold the line between reads.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         abc_q     <= '0;
         abc_vld_q <= 1'b0;
         ucn_out_q <= 1'b0;
         fov_out_q <= 1'b0;
      end else begin
         abc_vld_q <= vld_q[RL];
         ucn_out_q <= vld_q[RL] & ucn_q[RL];
         fov_out_q <= vld_q[RL] & fov_q[RL];
         if (vld_q[RL]) abc_q <= pipe_q[RL];
      end
   end

   assign instr_ready_out             = ready_q;
   assign abc_out                     = abc_q;
   assign abc_valid_out               = abc_vld_q;
   assign use_new_c_out               = ucn_out_q;
   assign fma_output_can_be_valid_out = fov_out_q;
   assign busy_out                    = (state_q == S_WAIT_WB) | (|vld_q);
   assign error_out                   = err_q;

endmodule
